// File: rtl/alu_dispatch.sv
// Single-issue ALU dispatcher: accepts one instruction, reads operands from the
// register file, drives the ALU, waits for its result and writes it back.
module alu_dispatch #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        inst_ready,
  output logic [4:0]  rf_rd_addr,
  output logic [4:0]  rf_rs_addr,
  output logic [4:0]  rf_rt_addr,
  input  logic [63:0] rf_rd_data,
  input  logic [63:0] rf_rs_data,
  input  logic [63:0] rf_rt_data,
  output logic [63:0] alu_rd_val,
  output logic [63:0] alu_rs_val,
  output logic [63:0] alu_rt_val,
  output logic [11:0] alu_imm,
  output logic [4:0]  alu_opcode,
  output logic        alu_start,
  input  logic [63:0] alu_result,
  input  logic [1:0]  alu_ready,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [63:0] wb_data,
  output logic        illegal,
  output logic        timeout_err,
  output logic [31:0] retired_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_r;
  logic [4:0]  op_r;
  logic [4:0]  rd_r;
  logic [4:0]  rs_r;
  logic [4:0]  rt_r;
  logic [11:0] imm_r;
  logic [7:0]  wait_cnt_r;
  logic        handshake_s;
  logic        legal_s;
  logic        ready_hi_unused_s;

  function automatic logic is_legal(input logic [4:0] op);
    return (op <= 5'd13) || ((op >= 5'd25) && (op <= 5'd28));
  endfunction

  assign rf_rd_addr        = rd_r;
  assign rf_rs_addr        = rs_r;
  assign rf_rt_addr        = rt_r;
  assign ready_hi_unused_s = alu_ready[1];

  // Decode of the offered instruction; only meaningful while IDLE.
  always_comb begin
    handshake_s = inst_valid & inst_ready;
    legal_s     = is_legal(inst[31:27]);
  end

  // Dispatch FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      op_r        <= 5'd0;
      rd_r        <= 5'd0;
      rs_r        <= 5'd0;
      rt_r        <= 5'd0;
      imm_r       <= 12'd0;
      wait_cnt_r  <= 8'd0;
      inst_ready  <= 1'b1;
      alu_rd_val  <= 64'd0;
      alu_rs_val  <= 64'd0;
      alu_rt_val  <= 64'd0;
      alu_imm     <= 12'd0;
      alu_opcode  <= 5'd0;
      alu_start   <= 1'b0;
      wb_en       <= 1'b0;
      wb_addr     <= 5'd0;
      wb_data     <= 64'd0;
      illegal     <= 1'b0;
      timeout_err <= 1'b0;
      retired_cnt <= 32'd0;
    end else begin
      alu_start <= 1'b0;
      illegal   <= 1'b0;
      wb_en     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (handshake_s) begin
            op_r  <= inst[31:27];
            rd_r  <= inst[26:22];
            rs_r  <= inst[21:17];
            rt_r  <= inst[16:12];
            imm_r <= inst[11:0];
            if (legal_s) begin
              state_r    <= ST_ISSUE;
              inst_ready <= 1'b0;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          // Operands are frozen here and stay put until the next ISSUE.
          alu_rd_val <= rf_rd_data;
          alu_rs_val <= rf_rs_data;
          alu_rt_val <= rf_rt_data;
          alu_imm    <= imm_r;
          alu_opcode <= op_r;
          alu_start  <= 1'b1;
          wait_cnt_r <= 8'd0;
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (alu_ready[0]) begin
            wb_en   <= 1'b1;
            wb_addr <= rd_r;
            wb_data <= alu_result;
            state_r <= ST_WB;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
            if (wait_cnt_r == WAIT_LAST) begin
              timeout_err <= 1'b1;
              inst_ready  <= 1'b1;
              state_r     <= ST_IDLE;
            end
          end
        end
        ST_WB: begin
          retired_cnt <= retired_cnt + 32'd1;
          inst_ready  <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          inst_ready <= 1'b1;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch (MAX_WAIT=4) with a behavioural register file.
module tb_alu_dispatch;

  logic        clk;
  logic        reset;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic [4:0]  rf_rd_addr, rf_rs_addr, rf_rt_addr;
  logic [63:0] rf_rd_data, rf_rs_data, rf_rt_data;
  logic [63:0] alu_rd_val, alu_rs_val, alu_rt_val;
  logic [11:0] alu_imm;
  logic [4:0]  alu_opcode;
  logic        alu_start;
  logic [63:0] alu_result;
  logic [1:0]  alu_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        illegal;
  logic        timeout_err;
  logic [31:0] retired_cnt;

  logic [63:0] regs [32];
  logic [4:0]  bad_ops [4];
  int          passed;
  int          total;

  alu_dispatch #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
    .rf_rd_addr(rf_rd_addr), .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
    .rf_rd_data(rf_rd_data), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .alu_rd_val(alu_rd_val), .alu_rs_val(alu_rs_val), .alu_rt_val(alu_rt_val),
    .alu_imm(alu_imm), .alu_opcode(alu_opcode), .alu_start(alu_start),
    .alu_result(alu_result), .alu_ready(alu_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal), .timeout_err(timeout_err), .retired_cnt(retired_cnt)
  );

  assign rf_rd_data = regs[rf_rd_addr];
  assign rf_rs_data = regs[rf_rs_addr];
  assign rf_rt_data = regs[rf_rt_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [11:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  initial begin
    passed = 0;
    total  = 0;
    for (int i = 0; i < 32; i++) regs[i] = 64'(i) * 64'h1111;
    regs[1] = 64'd5;
    regs[2] = 64'd7;
    bad_ops = '{5'd14, 5'd16, 5'd24, 5'd29};
    reset = 1'b1; inst_valid = 1'b0; inst = 32'd0;
    alu_ready = 2'b00; alu_result = 64'd0;

    tick(); tick();
    chk("rst_inst_ready", inst_ready, 64'd1);
    chk("rst_alu_start", alu_start, 64'd0);
    chk("rst_wb_en", wb_en, 64'd0);
    chk("rst_illegal", illegal, 64'd0);
    chk("rst_timeout", timeout_err, 64'd0);
    chk("rst_retired", retired_cnt, 64'd0);
    chk("rst_alu_rs_val", alu_rs_val, 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_ready", inst_ready, 64'd1);

    // ADD r3 = r1 + r2, ALU answers in the start cycle: 4-cycle turnaround
    inst = mk(5'd0, 5'd3, 5'd1, 5'd2, 12'd0); inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    chk("add_issue_ready", inst_ready, 64'd0);
    chk("add_rf_rd", rf_rd_addr, 64'd3);
    chk("add_rf_rs", rf_rs_addr, 64'd1);
    chk("add_rf_rt", rf_rt_addr, 64'd2);
    chk("add_issue_start", alu_start, 64'd0);
    tick();
    chk("add_start", alu_start, 64'd1);
    chk("add_rs_val", alu_rs_val, 64'd5);
    chk("add_rt_val", alu_rt_val, 64'd7);
    chk("add_rd_val", alu_rd_val, 64'h3333);
    chk("add_wait_wb_en", wb_en, 64'd0);
    alu_ready = 2'b01; alu_result = 64'd12;
    tick();
    chk("add_wb_en", wb_en, 64'd1);
    chk("add_wb_addr", wb_addr, 64'd3);
    chk("add_wb_data", wb_data, 64'd12);
    chk("add_start_once", alu_start, 64'd0);
    chk("add_wb_ready", inst_ready, 64'd0);
    alu_ready = 2'b00; alu_result = 64'd0;
    tick();
    chk("add_ready_back", inst_ready, 64'd1);
    chk("add_retired", retired_cnt, 64'd1);
    chk("add_wb_off", wb_en, 64'd0);

    // illegal opcodes just outside the legal ranges
    for (int i = 0; i < 4; i++) begin
      inst = mk(bad_ops[i], 5'd4, 5'd1, 5'd2, 12'd0); inst_valid = 1'b1;
      tick();
      inst_valid = 1'b0;
      chk("ill_pulse", illegal, 64'd1);
      chk("ill_ready", inst_ready, 64'd1);
      chk("ill_start", alu_start, 64'd0);
      tick();
      chk("ill_pulse_end", illegal, 64'd0);
      chk("ill_start2", alu_start, 64'd0);
      chk("ill_wb_en", wb_en, 64'd0);
      chk("ill_ready2", inst_ready, 64'd1);
    end

    // timeout: ALU never ready, only alu_ready[1] wiggles
    inst = mk(5'd1, 5'd4, 5'd5, 5'd6, 12'hABC); inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    tick();
    chk("to_imm_raw", alu_imm, 64'hABC);
    chk("to_opcode", alu_opcode, 64'd1);
    chk("to_rs_val", alu_rs_val, 64'h5555);
    alu_ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait_wb_en", wb_en, 64'd0);
      chk("to_wait_ready", inst_ready, 64'd0);
      chk("to_imm_hold", alu_imm, 64'hABC);
    end
    chk("to_not_yet", timeout_err, 64'd0);
    tick();
    alu_ready = 2'b00;
    chk("to_flag", timeout_err, 64'd1);
    chk("to_ready", inst_ready, 64'd1);
    chk("to_wb_en", wb_en, 64'd0);
    chk("to_retired", retired_cnt, 64'd1);

    // ADDI with top legal opcode still completes after the timeout
    inst = mk(5'd28, 5'd7, 5'd1, 5'd2, 12'h005); inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    tick();
    chk("addi_start", alu_start, 64'd1);
    chk("addi_imm", alu_imm, 64'h005);
    alu_ready = 2'b01; alu_result = 64'd10;
    tick();
    chk("addi_wb_en", wb_en, 64'd1);
    chk("addi_wb_addr", wb_addr, 64'd7);
    chk("addi_wb_data", wb_data, 64'd10);
    alu_ready = 2'b00;
    tick();
    chk("addi_retired", retired_cnt, 64'd2);
    chk("addi_sticky", timeout_err, 64'd1);

    // reset during WAIT, with a handshake offered during reset
    inst = mk(5'd2, 5'd9, 5'd1, 5'd2, 12'd0); inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    tick();
    chk("rstw_start", alu_start, 64'd1);
    reset = 1'b1; inst_valid = 1'b1; inst = mk(5'd3, 5'd9, 5'd1, 5'd2, 12'd0);
    tick();
    chk("rstw_ready", inst_ready, 64'd1);
    chk("rstw_wb_en", wb_en, 64'd0);
    chk("rstw_start_off", alu_start, 64'd0);
    chk("rstw_rs_val", alu_rs_val, 64'd0);
    chk("rstw_opcode", alu_opcode, 64'd0);
    chk("rstw_retired", retired_cnt, 64'd0);
    chk("rstw_timeout", timeout_err, 64'd0);
    chk("rstw_rf_rd", rf_rd_addr, 64'd0);
    reset = 1'b0; inst_valid = 1'b0;
    tick();
    chk("rstw_not_accepted", inst_ready, 64'd1);
    chk("rstw_rf_rd2", rf_rd_addr, 64'd0);

    // back-to-back: B waits while A takes a 3-cycle ALU
    inst = mk(5'd3, 5'd10, 5'd1, 5'd2, 12'd0); inst_valid = 1'b1;
    tick();
    inst = mk(5'd4, 5'd11, 5'd2, 5'd1, 12'd0);
    chk("b2b_issue_ready", inst_ready, 64'd0);
    tick();
    chk("b2b_a_start", alu_start, 64'd1);
    chk("b2b_a_rd", rf_rd_addr, 64'd10);
    tick(); tick(); tick();
    chk("b2b_hold_ready", inst_ready, 64'd0);
    chk("b2b_hold_rd", rf_rd_addr, 64'd10);
    alu_ready = 2'b01; alu_result = 64'd111;
    tick();
    chk("b2b_a_wb_en", wb_en, 64'd1);
    chk("b2b_a_wb_addr", wb_addr, 64'd10);
    chk("b2b_a_wb_data", wb_data, 64'd111);
    chk("b2b_a_no_timeout", timeout_err, 64'd0);
    alu_ready = 2'b00;
    tick();
    chk("b2b_idle_ready", inst_ready, 64'd1);
    chk("b2b_a_retired", retired_cnt, 64'd1);
    tick();
    inst_valid = 1'b0;
    chk("b2b_b_accepted", inst_ready, 64'd0);
    chk("b2b_b_rd", rf_rd_addr, 64'd11);
    tick();
    chk("b2b_b_rs_val", alu_rs_val, 64'd7);
    chk("b2b_b_rt_val", alu_rt_val, 64'd5);
    alu_ready = 2'b01; alu_result = 64'd222;
    tick();
    chk("b2b_b_wb_addr", wb_addr, 64'd11);
    chk("b2b_b_wb_data", wb_data, 64'd222);
    alu_ready = 2'b00;
    tick();
    chk("b2b_b_retired", retired_cnt, 64'd2);

    // retired counter wraps from all-ones
    force dut.retired_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retired_cnt;
    #1;
    chk("wrap_preload", retired_cnt, 64'hFFFF_FFFF);
    inst = mk(5'd5, 5'd12, 5'd1, 5'd2, 12'd0); inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    tick();
    alu_ready = 2'b01; alu_result = 64'd1;
    tick();
    chk("wrap_wb_en", wb_en, 64'd1);
    alu_ready = 2'b00;
    tick();
    chk("wrap_retired", retired_cnt, 64'd0);
    chk("wrap_wb_off", wb_en, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
